// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM acquisition sequencer.
package psram_pkg;

  localparam int unsigned DEF_ADDR_W     = 23;
  localparam int unsigned DEF_PAGE_BYTES = 1024;

  // read_write command encodings seen by the psram driver
  localparam logic [1:0] CMD_NONE     = 2'd0;
  localparam logic [1:0] CMD_WRITE_RW = 2'd1;
  localparam logic [1:0] CMD_READ_RW  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WR_ISSUE,
    ST_WR_BURST,
    ST_GAP,
    ST_FULL,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } acq_state_t;

endpackage

// File: rtl/psram_page_guard.sv
// Flags a write pointer sitting on the last word of a page or on the final address.
module psram_page_guard
  import psram_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       ADDR_STEP  = 2,
  parameter int unsigned       PAGE_BYTES = DEF_PAGE_BYTES,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFFE)
) (
  input  logic [ADDR_W-1:0] ptr,
  output logic              last_in_page,
  output logic              at_end
);

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [ADDR_W-1:0] PAGE_LAST = ADDR_W'(PAGE_BYTES - ADDR_STEP);

  // pure decode of the pointer against page and capacity limits
  always_comb begin
    last_in_page = ((ptr & PAGE_MASK) == PAGE_LAST);
    at_end       = (ptr == END_ADDR);
  end

endmodule

// File: rtl/psram_acq_ctrl.sv
// Sequencer feeding sample-FIFO data into PSRAM as page-bounded burst writes,
// with single-word readback between acquisitions.
module psram_acq_ctrl
  import psram_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       ADDR_STEP  = 2,
  parameter int unsigned       PAGE_BYTES = DEF_PAGE_BYTES,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFFE),
  parameter int unsigned       GAP_CYCLES = 4
) (
  input  logic              clk_PSRAM,
  input  logic              rst,
  input  logic              qpi_on,
  input  logic              start_acq,
  input  logic              stop_acq,
  input  logic              fifo_empty,
  input  logic              next_write,
  input  logic              endcommand,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        read_write,
  output logic              quad_start,
  output logic              burst_mode,
  output logic              stop_acquisition,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              busy,
  output logic              full,
  output logic              rd_valid
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  acq_state_t        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic              wrote_end;
  logic              gap_after_read;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic              nxt_last;
  logic              nxt_end;

  // pointer after this cycle's commit; holds at END_ADDR instead of wrapping
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (state == ST_WR_BURST && next_write && wr_ptr != END_ADDR)
      wr_ptr_nxt = wr_ptr + ADDR_W'(ADDR_STEP);
  end

  // guard looks at the next pointer so stop_acquisition lines up with the
  // registered wr_ptr of the word currently being written
  psram_page_guard #(
    .ADDR_W    (ADDR_W),
    .ADDR_STEP (ADDR_STEP),
    .PAGE_BYTES(PAGE_BYTES),
    .END_ADDR  (END_ADDR)
  ) u_guard (
    .ptr         (wr_ptr_nxt),
    .last_in_page(nxt_last),
    .at_end      (nxt_end)
  );

  // acquisition / readback FSM with registered outputs
  always_ff @(posedge clk_PSRAM or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      address          <= '0;
      read_write       <= CMD_NONE;
      quad_start       <= 1'b0;
      burst_mode       <= 1'b0;
      stop_acquisition <= 1'b0;
      wr_ptr           <= '0;
      busy             <= 1'b0;
      full             <= 1'b0;
      rd_valid         <= 1'b0;
      gap_cnt          <= '0;
      wrote_end        <= 1'b0;
      gap_after_read   <= 1'b0;
    end else begin
      quad_start <= 1'b0;
      rd_valid   <= 1'b0;
      case (state)
        ST_IDLE, ST_FULL: begin
          if (qpi_on && start_acq) begin
            wr_ptr     <= '0;
            wrote_end  <= 1'b0;
            full       <= 1'b0;
            burst_mode <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_ARM;
          end else if (qpi_on && read_req) begin
            address    <= read_addr;
            read_write <= CMD_READ_RW;
            quad_start <= 1'b1;
            burst_mode <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_RD_ISSUE;
          end
        end
        ST_ARM: begin
          if (stop_acq) begin
            burst_mode <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (!fifo_empty) begin
            address          <= wr_ptr;
            read_write       <= CMD_WRITE_RW;
            burst_mode       <= 1'b1;
            quad_start       <= 1'b1;
            stop_acquisition <= nxt_last || nxt_end;
            state            <= ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          stop_acquisition <= nxt_last || nxt_end || stop_acq;
          state            <= ST_WR_BURST;
        end
        ST_WR_BURST: begin
          wr_ptr <= wr_ptr_nxt;
          if (next_write && wr_ptr == END_ADDR)
            wrote_end <= 1'b1;
          if (endcommand) begin
            read_write       <= CMD_NONE;
            stop_acquisition <= 1'b0;
            gap_cnt          <= '0;
            gap_after_read   <= 1'b0;
            state            <= ST_GAP;
          end else begin
            stop_acquisition <= nxt_last || nxt_end || stop_acq;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            if (gap_after_read) begin
              busy  <= 1'b0;
              state <= full ? ST_FULL : ST_IDLE;
            end else if (wrote_end) begin
              full       <= 1'b1;
              burst_mode <= 1'b0;
              busy       <= 1'b0;
              state      <= ST_FULL;
            end else if (stop_acq) begin
              burst_mode <= 1'b0;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              state <= ST_ARM;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (endcommand) begin
            read_write     <= CMD_NONE;
            rd_valid       <= 1'b1;
            gap_cnt        <= '0;
            gap_after_read <= 1'b1;
            state          <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_acq_ctrl.sv
// Scoreboard bench for psram_acq_ctrl; END_ADDR is shrunk to two pages.
module tb_psram_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst, qpi_on, start_acq, stop_acq, fifo_empty;
  logic        next_write, endcommand, read_req;
  logic [22:0] read_addr;
  logic [22:0] address, wr_ptr;
  logic [1:0]  read_write;
  logic        quad_start, burst_mode, stop_acquisition, busy, full, rd_valid;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [24:0] exp_q[$];   // {read_write, address} per expected command
  logic        prev_qs = 1'b0;

  always #6 clk = ~clk;

  psram_acq_ctrl #(.END_ADDR(23'h0007FE)) dut (
    .clk_PSRAM       (clk),
    .rst             (rst),
    .qpi_on          (qpi_on),
    .start_acq       (start_acq),
    .stop_acq        (stop_acq),
    .fifo_empty      (fifo_empty),
    .next_write      (next_write),
    .endcommand      (endcommand),
    .read_req        (read_req),
    .read_addr       (read_addr),
    .address         (address),
    .read_write      (read_write),
    .quad_start      (quad_start),
    .burst_mode      (burst_mode),
    .stop_acquisition(stop_acquisition),
    .wr_ptr          (wr_ptr),
    .busy            (busy),
    .full            (full),
    .rd_valid        (rd_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nw(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      next_write = 1'b1;
      @(negedge clk);
      next_write = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_end();
    endcommand = 1'b1;
    @(negedge clk);
    endcommand = 1'b0;
  endtask

  task automatic wait_qs(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (quad_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_qs_seen"}, 32'(quad_start), 32'd1);
  endtask

  task automatic do_read(input logic [22:0] a, input logic exp_full);
    read_addr = a;
    exp_q.push_back({2'd2, a});
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    wait_qs(8, "rd");
    check("rd_burst_mode", 32'(burst_mode), 32'd0);
    @(negedge clk);
    check("rd_rw_held", 32'(read_write), 32'd2);
    tick(3);
    pulse_end();
    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
    @(negedge clk);
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    tick(8);
    check("rd_ret_full", 32'(full), 32'(exp_full));
    check("rd_ret_busy", 32'(busy), 32'd0);
  endtask

  // scoreboard: every command start must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && quad_start) begin
      check("qs_single_cycle", 32'(prev_qs), 32'd0);
      check("qs_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("qs_cmd", 32'({read_write, address}), 32'(exp_q.pop_front()));
    end
    prev_qs = quad_start;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b1; qpi_on = 1'b0; start_acq = 1'b0; stop_acq = 1'b0;
    fifo_empty = 1'b1; next_write = 1'b0; endcommand = 1'b0;
    read_req = 1'b0; read_addr = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_address", 32'(address), 32'd0);
    check("rst_rw", 32'(read_write), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_flags", 32'({quad_start, burst_mode, stop_acquisition, busy, full, rd_valid}), 32'd0);

    // start without QPI init is ignored
    fifo_empty = 1'b0;
    start_acq = 1'b1; @(negedge clk); start_acq = 1'b0;
    tick(5);
    check("noqpi_busy", 32'(busy), 32'd0);

    // first burst at address 0
    qpi_on = 1'b1;
    exp_q.push_back({2'd1, 23'd0});
    start_acq = 1'b1; @(negedge clk); start_acq = 1'b0;
    wait_qs(8, "wr0");
    check("wr0_burst_mode", 32'(burst_mode), 32'd1);
    tick(1);
    check("wr0_rw_held", 32'(read_write), 32'd1);
    nw(10);
    check("wr0_ptr", 32'(wr_ptr), 32'd20);
    exp_q.push_back({2'd1, 23'd20});
    pulse_end();
    check("wr0_rw_clear", 32'(read_write), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    n = 1;
    while (quad_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gap_qs_seen", 32'(quad_start), 32'd1);
    check("gap_len_ok", 32'(n >= 5 && n <= 10), 32'd1);

    // run up to the first page boundary
    tick(1);
    nw(500);
    check("pg_ptr_1020", 32'(wr_ptr), 32'd1020);
    check("pg_stop_low", 32'(stop_acquisition), 32'd0);
    nw(1);
    check("pg_ptr_1022", 32'(wr_ptr), 32'd1022);
    check("pg_stop_high", 32'(stop_acquisition), 32'd1);
    nw(1);
    check("pg_ptr_1024", 32'(wr_ptr), 32'd1024);
    exp_q.push_back({2'd1, 23'd1024});
    pulse_end();
    wait_qs(20, "pg2");

    // second page runs into END_ADDR and saturates
    tick(1);
    nw(511);
    check("end_ptr", 32'(wr_ptr), 32'h7FE);
    check("end_stop_high", 32'(stop_acquisition), 32'd1);
    nw(1);
    check("end_ptr_sat", 32'(wr_ptr), 32'h7FE);
    pulse_end();
    tick(10);
    check("full_set", 32'(full), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_burst_mode", 32'(burst_mode), 32'd0);
    nw(2);
    tick(4);
    check("full_ptr_hold", 32'(wr_ptr), 32'h7FE);

    // readback from FULL returns to FULL
    do_read(23'h000123, 1'b1);

    // restart from FULL, then stop mid-burst
    exp_q.push_back({2'd1, 23'd0});
    start_acq = 1'b1; @(negedge clk); start_acq = 1'b0;
    wait_qs(8, "restart");
    tick(1);
    check("restart_full_clr", 32'(full), 32'd0);
    nw(3);
    check("restart_ptr", 32'(wr_ptr), 32'd6);
    stop_acq = 1'b1;
    tick(1);
    check("stop_req_stop", 32'(stop_acquisition), 32'd1);
    pulse_end();
    tick(8);
    check("stop_idle_busy", 32'(busy), 32'd0);
    stop_acq = 1'b0;
    tick(4);
    check("stop_stays_idle", 32'(busy), 32'd0);

    // readback from IDLE
    do_read(23'h000100, 1'b0);

    // ARM with empty FIFO, stop exits immediately
    fifo_empty = 1'b1;
    start_acq = 1'b1; @(negedge clk); start_acq = 1'b0;
    tick(3);
    check("arm_busy", 32'(busy), 32'd1);
    stop_acq = 1'b1;
    tick(2);
    check("arm_stop_idle", 32'(busy), 32'd0);
    stop_acq = 1'b0;

    // stray endcommand in IDLE
    pulse_end();
    tick(2);
    check("idle_endcmd_ignored", 32'({busy, rd_valid}), 32'd0);

    // start beats a simultaneous read; then async reset mid-burst
    fifo_empty = 1'b0;
    read_addr = 23'h000200;
    exp_q.push_back({2'd1, 23'd0});
    start_acq = 1'b1; read_req = 1'b1;
    @(negedge clk);
    start_acq = 1'b0; read_req = 1'b0;
    wait_qs(8, "prio");
    tick(1);
    nw(2);
    check("prio_ptr", 32'(wr_ptr), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("arst_rw", 32'(read_write), 32'd0);
    check("arst_flags", 32'({quad_start, burst_mode, stop_acquisition, busy, full, rd_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    check("q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
